// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES core scheduler.
package aes_sched_pkg;

  localparam int AES_BLK_W       = 128;
  localparam int TIMEOUT_CYC_DEF = 31;

  typedef enum logic [2:0] {IDLE, LOAD, BUSY, RESP, ABORT} sched_state_e;

  // Timer only has to reach TIMEOUT_CYC-1.
  function automatic int timer_w(input int timeout_cyc);
    return (timeout_cyc > 1) ? $clog2(timeout_cyc) : 1;
  endfunction

  localparam int TIMER_W_DEF = timer_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/aes_core_sched_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx;

  // Scan farthest-first so the closest requester to ptr is the last writer.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    idx        = '0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = IW'((int'(ptr) + off) % N);
      if (req[idx]) begin
        gnt_onehot      = '0;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/aes_core_sched.sv
// Shares one AES-128 core between N_REQ requesters; round-robin grant,
// timeout with core recovery, tagged valid/ready response.
module aes_core_sched
  import aes_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*AES_BLK_W-1:0]   req_key,
  input  logic [N_REQ*AES_BLK_W-1:0]   req_text,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [AES_BLK_W-1:0]         rsp_data,
  output logic                         rsp_err,
  output logic                         busy,
  output logic                         core_rst,
  output logic                         core_ld,
  output logic [AES_BLK_W-1:0]         core_key,
  output logic [AES_BLK_W-1:0]         core_text_in,
  input  logic                         core_done,
  input  logic [AES_BLK_W-1:0]         core_text_out
);

  localparam int TMR_W = timer_w(TIMEOUT_CYC);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [AES_BLK_W-1:0] key_q, key_d, text_q, text_d, data_q, data_d;
  logic                 err_q, err_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [N_REQ-1:0]     gnt_onehot;
  logic [ID_W-1:0]      gnt_idx;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  assign req_ready    = (state_q == IDLE) ? gnt_onehot : '0;
  assign core_ld      = (state_q == LOAD);
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  // Core held in reset while we are, and for the single ABORT cycle.
  assign core_rst     = rst && (state_q != ABORT);
  assign rsp_id       = id_q;
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;
  assign core_key     = key_q;
  assign core_text_in = text_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    key_d    = key_q;
    text_d   = text_q;
    data_d   = data_q;
    err_d    = err_q;
    tmr_d    = tmr_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        key_d   = req_key[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
        text_d  = req_text[int'(gnt_idx)*AES_BLK_W +: AES_BLK_W];
        id_d    = gnt_idx;
        state_d = LOAD;
      end
      LOAD: begin
        tmr_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        tmr_d = tmr_q + 1'b1;
        // done beats a coincident timeout
        if (core_done) begin
          data_d  = core_text_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT: state_d = RESP;
      RESP: if (rsp_ready) begin
        rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      key_q    <= '0;
      text_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      key_q    <= key_d;
      text_q   <= text_d;
      data_q   <= data_d;
      err_q    <= err_d;
      tmr_q    <= tmr_d;
    end
  end

endmodule

// File: tb/tb_aes_core_sched.sv
// Randomized bench for aes_core_sched with a stub core and a grant/response model.
module tb_aes_core_sched;

  localparam int N  = 4;
  localparam int TO = 31;
  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic           clk, rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*128-1:0] req_key, req_text;
  logic           rsp_valid, rsp_ready, rsp_err, busy;
  logic [1:0]     rsp_id;
  logic [127:0]   rsp_data;
  logic           core_rst, core_ld, core_done;
  logic [127:0]   core_key, core_text_in, core_text_out;

  aes_core_sched #(.N_REQ(N), .ID_W(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_text(req_text), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .core_rst(core_rst), .core_ld(core_ld),
    .core_key(core_key), .core_text_in(core_text_in), .core_done(core_done),
    .core_text_out(core_text_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int ld_cnt = 0, ld_exp = 0;
  int m_ptr = 0;
  logic [127:0] m_key [N];
  logic [127:0] m_text[N];

  always @(posedge clk) if (rst && core_ld) ld_cnt <= ld_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: the scheduler only moves data, so any keyed mix works.
  function automatic logic [127:0] fake_enc(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_K && p == FIPS_P) return FIPS_C;
    return {k[63:0], k[127:64]} ^ p ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (p + k) % N;
      if (v[idx[1:0]]) return idx;
    end
    return 0;
  endfunction

  task automatic drive_reqs(input logic [N-1:0] v);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_key[i*128 +: 128]  = m_key[i];
      req_text[i*128 +: 128] = m_text[i];
    end
  endtask

  task automatic run_op(input logic [N-1:0] v, input int lat, input int stall, input bit keep);
    int g;
    logic [1:0] gi;
    logic [N-1:0] exp_rdy;
    logic [127:0] exp_d;
    bit exp_e;
    g = pick(v, m_ptr);
    gi = 2'(g);
    exp_rdy = '0;
    exp_rdy[gi] = 1'b1;
    drive_reqs(v);
    #1;
    chk("grant", 128'(req_ready), 128'(exp_rdy));
    chk("idle_busy", 128'(busy), 128'(0));
    @(negedge clk);
    if (!keep) req_valid[gi] = 1'b0;
    #1;
    chk("ld", 128'(core_ld), 128'(1));
    chk("core_key", core_key, m_key[g]);
    chk("core_text", core_text_in, m_text[g]);
    chk("rdy_load", 128'(req_ready), 128'(0));
    ld_exp++;
    exp_e = (lat >= TO);
    exp_d = exp_e ? 128'(0) : fake_enc(m_key[g], m_text[g]);
    for (int n = 0; n < TO; n++) begin
      @(negedge clk);
      #1;
      chk("busy_pins", 128'({core_ld, rsp_valid, core_rst, |req_ready, busy}), 128'(5'b00101));
      if (n == lat) begin
        core_done = 1'b1;
        core_text_out = fake_enc(core_key, core_text_in);
        break;
      end
    end
    @(negedge clk);
    core_done = 1'b0;
    core_text_out = rnd128();
    if (exp_e) begin
      #1;
      chk("abort_rst", 128'(core_rst), 128'(0));
      chk("abort_vld", 128'(rsp_valid), 128'(0));
      @(negedge clk);
    end
    for (int s = 0; s <= stall; s++) begin
      if (s == 1) begin core_done = 1'b1; core_text_out = ~exp_d; end
      if (s == 2) core_done = 1'b0;
      rsp_ready = (s == stall);
      #1;
      chk("core_rst_hi", 128'(core_rst), 128'(1));
      chk("rsp_valid", 128'(rsp_valid), 128'(1));
      chk("rsp_id", 128'(rsp_id), 128'(g));
      chk("rsp_data", rsp_data, exp_d);
      chk("rsp_err", 128'(rsp_err), 128'(exp_e));
      chk("rdy_resp", 128'(req_ready), 128'(0));
      chk("ld_count", 128'(ld_cnt), 128'(ld_exp));
      @(negedge clk);
    end
    core_done = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("post_vld", 128'(rsp_valid), 128'(0));
    chk("post_busy", 128'(busy), 128'(0));
    m_ptr = (g + 1) % N;
    m_key[g]  = rnd128();
    m_text[g] = rnd128();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pins"}, 128'({rsp_valid, rsp_err, rsp_id, core_ld, busy, core_rst, req_ready}),
        128'(0));
    chk({tag, "_data"}, rsp_data, 128'(0));
    chk({tag, "_key"}, core_key, 128'(0));
    chk({tag, "_text"}, core_text_in, 128'(0));
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; req_key = '0; req_text = '0;
    rsp_ready = 1'b0; core_done = 1'b0; core_text_out = '0;
    for (int i = 0; i < N; i++) begin m_key[i] = rnd128(); m_text[i] = rnd128(); end
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    m_key[0] = FIPS_K; m_text[0] = FIPS_P;
    run_op(4'b0001, 10, 0, 1'b0);

    for (int k = 0; k < 5; k++) run_op(4'b1111, int'($urandom_range(0, 8)), 0, 1'b1);

    run_op(4'($urandom_range(1, 15)), 4, 10, 1'b0);
    run_op(4'($urandom_range(1, 15)), 999, 1, 1'b0);
    run_op(4'($urandom_range(1, 15)), 3, 0, 1'b0);
    run_op(4'($urandom_range(1, 15)), TO - 1, 2, 1'b0);

    req_valid = '0;
    @(negedge clk);
    #1;
    chk("no_req_ready", 128'(req_ready), 128'(0));
    chk("no_req_busy", 128'(busy), 128'(0));

    for (int k = 0; k < 20; k++)
      run_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 35)),
             int'($urandom_range(0, 3)), 1'b0);

    // abandon an operation mid-BUSY
    m_ptr = 2;
    while (m_ptr != 2) ;
    drive_reqs(4'b1100);
    @(negedge clk);
    ld_exp++;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    #1;
    chk("mid_rst_norsp", 128'(rsp_valid), 128'(0));
    chk("mid_rst_ld", 128'(ld_cnt), 128'(ld_exp));
    rst = 1'b1;
    m_ptr = 0;
    run_op(4'b1111, 5, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
